hilo_ctrl: RTL and testbench
============================

Name: hilo_ctrl

Overview:
Sequencer and architectural HI/LO register owner that sits between the multicycle datapath control and the iterative divider/multiplier units. It accepts DIV/DIVU-style and MULT requests and launches the appropriate unit with a one-cycle start pulse. It then counts that unit's fixed latency, captures its hi/lo outputs into HI/LO, and services MFHI/MFLO/MTHI/MTLO. Reads issued while an operation is in flight stall, and divide-by-zero is reported as an exception pulse.

Parameters:
DIV_LAT, 33, cycles from the div_start cycle to the cycle that captures div_hi_in/div_lo_in.
MULT_LAT, 33, cycles from the mult_start cycle to the cycle that captures mult_hi_in/mult_lo_in.
CNT_W, 6, counter width; must hold max(DIV_LAT, MULT_LAT).

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high
op_valid  in  1  request valid
op_code  in  3  0=NOP 1=DIV 2=MULT 3=MTHI 4=MTLO (others = NOP)
rs_val  in  32  operand A / MTx source
rt_val  in  32  operand B
op_ready  out  1  high in IDLE; request accepted when op_valid&op_ready
div_start  out  1  one-cycle start pulse to divider (its div_control)
div_a, div_b  out  32  divider operands, held stable for the whole run
div_hi_in, div_lo_in  in  32  divider remainder/quotient
div_zero_in  in  1  divider divide-by-zero flag
mult_start  out  1  one-cycle start pulse to multiplier
mult_a, mult_b  out  32  multiplier operands, held stable for the whole run
mult_hi_in, mult_lo_in  in  32  product high/low
rd_hi, rd_lo  in  1  MFHI/MFLO read request (mutually exclusive)
rd_data  out  32  HI or LO, combinational from registers
stall  out  1  read requested while busy
busy  out  1  state != IDLE
div_zero_exc  out  1  one-cycle exception pulse
hi_q, lo_q  out  32  architectural HI/LO

Behaviour:
- Reset (async): state=IDLE, cnt=0, HI=LO=0, div_a/b=mult_a/b=0, div_start=mult_start=div_zero_exc=0.
- States are IDLE, DIV_RUN, MULT_RUN.
- IDLE, accepted DIV:
  - Register div_a=rs_val and div_b=rt_val.
  - Assert div_start for the next cycle only (registered).
  - Go to DIV_RUN with cnt=1 in the div_start cycle.
- DIV_RUN:
  - cnt increments each cycle.
  - In the cycle with cnt==2 (first cycle after div_start), sample div_zero_in. If it is 1: pulse div_zero_exc for 1 cycle, leave HI/LO unchanged, return to IDLE.
  - Otherwise, on the cycle with cnt==DIV_LAT: HI<=div_hi_in, LO<=div_lo_in, return to IDLE.
- MULT: identical flow via mult_start/MULT_RUN/MULT_LAT, with no zero check.
- MTHI/MTLO in IDLE: HI (or LO) <= rs_val at the next edge; one cycle, state stays IDLE.
- NOP and undefined op_code: accepted, no effect.
- op_valid while busy: op_ready=0 and the request is not consumed. The requester holds it until accepted.
- Read path:
  - rd_data = HI when rd_hi, LO when rd_lo, else 0.
  - stall = (rd_hi|rd_lo) & busy; while stalled, rd_data still shows the old value, and the consumer must ignore it.
- Read and MTx in the same IDLE cycle: the read returns the pre-write value and stall=0.
- Operand registers stay unchanged until the next accepted op; they are not cleared on completion.
- Back-to-back: a new op may be accepted in the cycle after return to IDLE. Best-case issue rate is 1 per DIV_LAT+1 cycles.
- Reset mid-operation: immediate IDLE, no capture, and start pulses drop. The shared reset clears the divider/multiplier.
- All counters are unsigned and saturate nowhere; the FSM guarantees cnt never exceeds max latency.

Decomposition:
- Shared package (muldiv_pkg) holds:
  - op_code constants: OP_NOP, OP_DIV, OP_MULT, OP_MTHI, OP_MTLO.
  - State encoding.
  - Default latency constants DIV_LAT_DEF=33 and MULT_LAT_DEF=33.
- One natural sub-module: hilo_regfile, the two 32-bit registers with capture/MTx write muxing and the rd_data mux.
- The FSM and counter stay in hilo_ctrl.

Test Plan:
- DIV rs=7, rt=-2 (model returns hi=1, lo=-3 at cycle 33) -> div_start exactly 1 cycle; busy for 33 cycles; hi_q=1, lo_q=0xFFFFFFFD; op_ready returns high the next cycle.
- DIV rs=5, rt=0 with div_zero_in=1 in the post-start cycle -> div_zero_exc single-cycle pulse at cycle 2; HI/LO keep prior 0x11/0x22; IDLE.
- MULT rs=0x10000, rt=0x10000 (model hi=1, lo=0) -> hi_q=1, lo_q=0 after MULT_LAT; rd_lo at cycle 5 gives stall=1, and at completion+1 gives rd_data=0, stall=0.
- MTHI rs=0xDEADBEEF, then MFHI next cycle -> rd_data=0xDEADBEEF. Same-cycle MTLO 0x5 + rd_lo -> old LO returned, LO=5 afterward.
- DIV accepted, MULT held on op_valid during the run -> op_ready=0 for 33 cycles; MULT accepted the first IDLE cycle; mult_start appears one cycle later.
- Reset asserted at cycle 10 of a DIV -> all outputs zero asynchronously; no capture when reset releases; new DIV starts cleanly.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared op codes, sequencer state encoding and default unit latencies for the
// HI/LO sequencer and its divider/multiplier neighbours.
package muldiv_pkg;

    localparam int DIV_LAT_DEF  = 33;
    localparam int MULT_LAT_DEF = 33;
    localparam int CNT_W_DEF    = 6;

    typedef enum logic [2:0] {
        OP_NOP  = 3'd0,
        OP_DIV  = 3'd1,
        OP_MULT = 3'd2,
        OP_MTHI = 3'd3,
        OP_MTLO = 3'd4
    } op_code_e;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DIV_RUN  = 2'd1,
        ST_MULT_RUN = 2'd2
    } state_e;

endpackage

// File: rtl/hilo_ctrl_if.sv
// Request, unit and read-port signals of the HI/LO sequencer; slave is the
// sequencer itself, master is everything around it.
interface hilo_ctrl_if;

    logic        op_valid;
    logic [2:0]  op_code;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        op_ready;

    logic        div_start;
    logic [31:0] div_a;
    logic [31:0] div_b;
    logic [31:0] div_hi_in;
    logic [31:0] div_lo_in;
    logic        div_zero_in;

    logic        mult_start;
    logic [31:0] mult_a;
    logic [31:0] mult_b;
    logic [31:0] mult_hi_in;
    logic [31:0] mult_lo_in;

    logic        rd_hi;
    logic        rd_lo;
    logic [31:0] rd_data;
    logic        stall;
    logic        busy;
    logic        div_zero_exc;
    logic [31:0] hi_q;
    logic [31:0] lo_q;

    modport slave (
        input  op_valid, op_code, rs_val, rt_val,
        input  div_hi_in, div_lo_in, div_zero_in,
        input  mult_hi_in, mult_lo_in,
        input  rd_hi, rd_lo,
        output op_ready, div_start, div_a, div_b, mult_start, mult_a, mult_b,
        output rd_data, stall, busy, div_zero_exc, hi_q, lo_q
    );

    modport master (
        output op_valid, op_code, rs_val, rt_val,
        output div_hi_in, div_lo_in, div_zero_in,
        output mult_hi_in, mult_lo_in,
        output rd_hi, rd_lo,
        input  op_ready, div_start, div_a, div_b, mult_start, mult_a, mult_b,
        input  rd_data, stall, busy, div_zero_exc, hi_q, lo_q
    );

endinterface

// File: rtl/hilo_regfile.sv
// Architectural HI/LO pair: unit-result capture or MTHI/MTLO write, plus the
// combinational MFHI/MFLO read mux.
module hilo_regfile (
    input  logic        clk,
    input  logic        reset,
    input  logic        cap_div_i,
    input  logic        cap_mult_i,
    input  logic        mthi_i,
    input  logic        mtlo_i,
    input  logic [31:0] div_hi_i,
    input  logic [31:0] div_lo_i,
    input  logic [31:0] mult_hi_i,
    input  logic [31:0] mult_lo_i,
    input  logic [31:0] wr_data_i,
    input  logic        rd_hi_i,
    input  logic        rd_lo_i,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o,
    output logic [31:0] rd_data_o
);

    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;

    always_comb begin
        // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
        hi_d = hi_q;
        lo_d = lo_q;
        if (cap_div_i) begin
            hi_d = div_hi_i;
            lo_d = div_lo_i;
        end else if (cap_mult_i) begin
            hi_d = mult_hi_i;
            lo_d = mult_lo_i;
        end else begin
            if (mthi_i) hi_d = wr_data_i;
            if (mtlo_i) lo_d = wr_data_i;
        end
    end

    // NOTE: architectural state is reset (async) and updated with non-blocking assignments only.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hi_q <= '0;
            lo_q <= '0;
        end else begin
            hi_q <= hi_d;
            lo_q <= lo_d;
        end
    end

    // Reads see the pre-write value when an MTx lands in the same cycle.
    assign rd_data_o = rd_hi_i ? hi_q : (rd_lo_i ? lo_q : 32'd0);
    assign hi_o      = hi_q;
    assign lo_o      = lo_q;

endmodule

// File: rtl/hilo_ctrl.sv
// HI/LO sequencer: launches the divider or multiplier, counts its fixed latency,
// captures the result and services MTHI/MTLO and stalled MFHI/MFLO.
module hilo_ctrl
    import muldiv_pkg::*;
#(
    parameter int DIV_LAT  = DIV_LAT_DEF,
    parameter int MULT_LAT = MULT_LAT_DEF,
    parameter int CNT_W    = CNT_W_DEF
) (
    input  logic       clk,
    input  logic       reset,
    hilo_ctrl_if.slave bus
);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               div_start_q, div_start_d;
    logic               mult_start_q, mult_start_d;
    logic [31:0]        div_a_q, div_a_d, div_b_q, div_b_d;
    logic [31:0]        mult_a_q, mult_a_d, mult_b_q, mult_b_d;

    logic idle, zero_hit, cap_div, cap_mult, mthi_en, mtlo_en;

    // The divider flags divide-by-zero in the first cycle after its start pulse.
    assign zero_hit = (state_q == ST_DIV_RUN) && (cnt_q == CNT_W'(2)) && bus.div_zero_in;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            div_start_q  <= 1'b0;
            mult_start_q <= 1'b0;
            div_a_q      <= '0;
            div_b_q      <= '0;
            mult_a_q     <= '0;
            mult_b_q     <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            div_start_q  <= div_start_d;
            mult_start_q <= mult_start_d;
            div_a_q      <= div_a_d;
            div_b_q      <= div_b_d;
            mult_a_q     <= mult_a_d;
            mult_b_q     <= mult_b_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        div_start_d  = 1'b0;
        mult_start_d = 1'b0;
        div_a_d      = div_a_q;
        div_b_d      = div_b_q;
        mult_a_d     = mult_a_q;
        mult_b_d     = mult_b_q;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.op_valid) begin
                    case (bus.op_code)
                        OP_DIV: begin
                            state_d     = ST_DIV_RUN;
                            cnt_d       = CNT_W'(1);
                            div_start_d = 1'b1;
                            div_a_d     = bus.rs_val;
                            div_b_d     = bus.rt_val;
                        end
                        OP_MULT: begin
                            state_d      = ST_MULT_RUN;
                            cnt_d        = CNT_W'(1);
                            mult_start_d = 1'b1;
                            mult_a_d     = bus.rs_val;
                            mult_b_d     = bus.rt_val;
                        end
                        default: ;
                    endcase
                end
            end
            ST_DIV_RUN: begin
                if (zero_hit || cnt_q == CNT_W'(DIV_LAT)) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_MULT_RUN: begin
                if (cnt_q == CNT_W'(MULT_LAT)) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        idle     = (state_q == ST_IDLE);
        cap_div  = (state_q == ST_DIV_RUN) && (cnt_q == CNT_W'(DIV_LAT)) && !zero_hit;
        cap_mult = (state_q == ST_MULT_RUN) && (cnt_q == CNT_W'(MULT_LAT));
        mthi_en  = idle && bus.op_valid && (bus.op_code == OP_MTHI);
        mtlo_en  = idle && bus.op_valid && (bus.op_code == OP_MTLO);
    end

    assign bus.op_ready     = idle;
    assign bus.busy         = !idle;
    assign bus.stall        = (bus.rd_hi | bus.rd_lo) & !idle;
    assign bus.div_zero_exc = zero_hit;
    assign bus.div_start    = div_start_q;
    assign bus.mult_start   = mult_start_q;
    assign bus.div_a        = div_a_q;
    assign bus.div_b        = div_b_q;
    assign bus.mult_a       = mult_a_q;
    assign bus.mult_b       = mult_b_q;

    hilo_regfile u_regfile (
        .clk        (clk),
        .reset      (reset),
        .cap_div_i  (cap_div),
        .cap_mult_i (cap_mult),
        .mthi_i     (mthi_en),
        .mtlo_i     (mtlo_en),
        .div_hi_i   (bus.div_hi_in),
        .div_lo_i   (bus.div_lo_in),
        .mult_hi_i  (bus.mult_hi_in),
        .mult_lo_i  (bus.mult_lo_in),
        .wr_data_i  (bus.rs_val),
        .rd_hi_i    (bus.rd_hi),
        .rd_lo_i    (bus.rd_lo),
        .hi_o       (bus.hi_q),
        .lo_o       (bus.lo_q),
        .rd_data_o  (bus.rd_data)
    );

endmodule

// File: tb/tb_hilo_ctrl.sv
// Bench for hilo_ctrl: divider/multiplier stand-ins, a cycle-deadline reference
// model compared every cycle, and directed scenarios with literal expectations.
module tb_hilo_ctrl;
    import muldiv_pkg::*;

    localparam int DLAT = 33;
    localparam int MLAT = 33;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    hilo_ctrl_if bus ();

    hilo_ctrl #(.DIV_LAT(DLAT), .MULT_LAT(MLAT), .CNT_W(6)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Unit stand-ins: results are valid only in the cycle the sequencer must capture them.
    initial begin
        int u_cyc, d_at, m_at;
        logic [31:0] d_hi, d_lo, m_hi, m_lo;
        logic d_zero;
        longint prod;
        u_cyc = 0; d_at = -1000; m_at = -1000;
        d_hi = 0; d_lo = 0; m_hi = 0; m_lo = 0; d_zero = 1'b0;
        bus.div_hi_in = 0; bus.div_lo_in = 0; bus.div_zero_in = 1'b0;
        bus.mult_hi_in = 0; bus.mult_lo_in = 0;
        forever begin
            @(posedge clk);
            #1;
            u_cyc++;
            if (reset) begin
                d_at = -1000;
                m_at = -1000;
            end else begin
                if (bus.div_start) begin
                    d_at   = u_cyc;
                    d_zero = (bus.div_b == 32'd0);
                    d_hi   = d_zero ? 32'd0 : 32'($signed(bus.div_a) % $signed(bus.div_b));
                    d_lo   = d_zero ? 32'd0 : 32'($signed(bus.div_a) / $signed(bus.div_b));
                end
                if (bus.mult_start) begin
                    m_at = u_cyc;
                    prod = longint'($signed(bus.mult_a)) * longint'($signed(bus.mult_b));
                    m_hi = prod[63:32];
                    m_lo = prod[31:0];
                end
            end
            bus.div_hi_in   = (u_cyc == d_at + DLAT - 1) ? d_hi : (32'hA5A5_0000 ^ 32'(u_cyc));
            bus.div_lo_in   = (u_cyc == d_at + DLAT - 1) ? d_lo : (32'h5A5A_0000 ^ 32'(u_cyc));
            bus.mult_hi_in  = (u_cyc == m_at + MLAT - 1) ? m_hi : (32'hC3C3_0000 ^ 32'(u_cyc));
            bus.mult_lo_in  = (u_cyc == m_at + MLAT - 1) ? m_lo : (32'h3C3C_0000 ^ 32'(u_cyc));
            bus.div_zero_in = (u_cyc == d_at + 1) && d_zero;
        end
    end

    // Reference model: an accepted op at cycle t is busy over [t+1, t+LAT] and lands at t+LAT.
    int          t = 0;
    int          k_kind = 0;
    int          k_start = 0;
    int          k_end = 0;
    logic [31:0] e_hi = 0, e_lo = 0, k_rhi = 0, k_rlo = 0;
    logic [31:0] e_da = 0, e_db = 0, e_ma = 0, e_mb = 0, e_rd;
    logic        e_busy, e_exc, e_ds, e_ms;

    always @(negedge clk) begin
        t++;
        if (reset) begin
            k_kind = 0;
            e_hi = 0; e_lo = 0;
            e_da = 0; e_db = 0; e_ma = 0; e_mb = 0;
        end
        e_busy = (k_kind != 0);
        e_ds   = (k_kind == 1) && (t == k_start);
        e_ms   = (k_kind == 2) && (t == k_start);
        e_exc  = (k_kind == 1) && (t == k_start + 1) && (bus.div_zero_in === 1'b1);
        e_rd   = bus.rd_hi ? e_hi : (bus.rd_lo ? e_lo : 32'd0);
        check("op_ready",   32'(bus.op_ready),     32'(!e_busy));
        check("busy",       32'(bus.busy),         32'(e_busy));
        check("stall",      32'(bus.stall),        32'(e_busy && (bus.rd_hi || bus.rd_lo)));
        check("rd_data",    bus.rd_data,           e_rd);
        check("hi_q",       bus.hi_q,              e_hi);
        check("lo_q",       bus.lo_q,              e_lo);
        check("div_start",  32'(bus.div_start),    32'(e_ds));
        check("mult_start", 32'(bus.mult_start),   32'(e_ms));
        check("div_exc",    32'(bus.div_zero_exc), 32'(e_exc));
        check("div_a",      bus.div_a,             e_da);
        check("div_b",      bus.div_b,             e_db);
        check("mult_a",     bus.mult_a,            e_ma);
        check("mult_b",     bus.mult_b,            e_mb);
        if (!reset) begin
            if (k_kind == 0) begin
                if (bus.op_valid) begin
                    case (bus.op_code)
                        OP_DIV: begin
                            k_kind = 1; k_start = t + 1; k_end = t + DLAT;
                            e_da = bus.rs_val; e_db = bus.rt_val;
                            k_rhi = (bus.rt_val == 0) ? 32'd0 : 32'($signed(bus.rs_val) % $signed(bus.rt_val));
                            k_rlo = (bus.rt_val == 0) ? 32'd0 : 32'($signed(bus.rs_val) / $signed(bus.rt_val));
                        end
                        OP_MULT: begin
                            k_kind = 2; k_start = t + 1; k_end = t + MLAT;
                            e_ma = bus.rs_val; e_mb = bus.rt_val;
                            {k_rhi, k_rlo} = 64'(longint'($signed(bus.rs_val)) * longint'($signed(bus.rt_val)));
                        end
                        OP_MTHI: e_hi = bus.rs_val;
                        OP_MTLO: e_lo = bus.rs_val;
                        default: ;
                    endcase
                end
            end else if (e_exc) begin
                k_kind = 0;
            end else if (t == k_end) begin
                e_hi = k_rhi;
                e_lo = k_rlo;
                k_kind = 0;
            end
        end
    end

    task automatic step;
        @(posedge clk);
        #2;
    endtask

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         output int waited);
        bus.op_valid = 1'b1;
        bus.op_code  = op;
        bus.rs_val   = a;
        bus.rt_val   = b;
        waited = 0;
        while (!bus.op_ready && waited < 200) begin
            step();
            waited++;
        end
        if (!bus.op_ready) check("accept_timeout", 32'(bus.op_ready), 32'd1);
        step();
        bus.op_valid = 1'b0;
        bus.op_code  = OP_NOP;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (bus.busy && n < 200) begin
            step();
            n++;
        end
        check("idle_timeout", 32'(bus.busy), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        int w, n;
        reset = 1'b1;
        bus.op_valid = 1'b0; bus.op_code = OP_NOP;
        bus.rs_val = 0; bus.rt_val = 0;
        bus.rd_hi = 1'b0; bus.rd_lo = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check("rst_hi",    bus.hi_q, 32'd0);
        check("rst_lo",    bus.lo_q, 32'd0);
        check("rst_ready", 32'(bus.op_ready), 32'd1);
        reset = 1'b0;
        step();

        // DIV 7 / -2 -> quotient -3, remainder 1.
        issue(OP_DIV, 32'd7, 32'hFFFF_FFFE, w);
        check("t1_start", 32'(bus.div_start), 32'd1);
        wait_idle(n);
        check("t1_busy_cycles", 32'(n), 32'd33);
        check("t1_hi", bus.hi_q, 32'd1);
        check("t1_lo", bus.lo_q, 32'hFFFF_FFFD);
        check("t1_ready", 32'(bus.op_ready), 32'd1);

        // Divide by zero leaves HI/LO alone and returns to idle.
        issue(OP_MTHI, 32'h11, 32'd0, w);
        issue(OP_MTLO, 32'h22, 32'd0, w);
        issue(OP_DIV, 32'd5, 32'd0, w);
        step();
        check("t2_exc", 32'(bus.div_zero_exc), 32'd1);
        step();
        check("t2_exc_end", 32'(bus.div_zero_exc), 32'd0);
        check("t2_idle", 32'(bus.busy), 32'd0);
        check("t2_hi", bus.hi_q, 32'h11);
        check("t2_lo", bus.lo_q, 32'h22);

        // MULT 0x10000 * 0x10000 = 1 << 32, with a stalled MFLO in flight.
        issue(OP_MULT, 32'h1_0000, 32'h1_0000, w);
        repeat (4) step();
        bus.rd_lo = 1'b1;
        #1;
        check("t3_stall", 32'(bus.stall), 32'd1);
        wait_idle(n);
        #1;
        check("t3_rd", bus.rd_data, 32'd0);
        check("t3_nostall", 32'(bus.stall), 32'd0);
        check("t3_hi", bus.hi_q, 32'd1);
        bus.rd_lo = 1'b0;

        // MTHI then MFHI; MTLO with MFLO in the same cycle returns the old LO.
        issue(OP_MTHI, 32'hDEAD_BEEF, 32'd0, w);
        bus.rd_hi = 1'b1;
        #1;
        check("t4_mfhi", bus.rd_data, 32'hDEAD_BEEF);
        bus.rd_hi = 1'b0;
        bus.op_valid = 1'b1; bus.op_code = OP_MTLO; bus.rs_val = 32'd5;
        bus.rd_lo = 1'b1;
        #1;
        check("t4_old_lo", bus.rd_data, 32'd0);
        check("t4_nostall", 32'(bus.stall), 32'd0);
        step();
        bus.op_valid = 1'b0; bus.op_code = OP_NOP; bus.rd_lo = 1'b0;
        #1;
        check("t4_lo", bus.lo_q, 32'd5);

        // MULT held behind a running DIV (100 / 7), then 3 * 4.
        issue(OP_DIV, 32'd100, 32'd7, w);
        issue(OP_MULT, 32'd3, 32'd4, w);
        check("t5_ready_low", 32'(w), 32'd33);
        check("t5_mstart", 32'(bus.mult_start), 32'd1);
        wait_idle(n);
        check("t5_hi", bus.hi_q, 32'd0);
        check("t5_lo", bus.lo_q, 32'd12);

        // Reset at cycle 10 of a DIV: everything clears, nothing is captured later.
        issue(OP_DIV, 32'd9, 32'd2, w);
        repeat (9) step();
        reset = 1'b1;
        #1;
        check("t6_busy", 32'(bus.busy), 32'd0);
        check("t6_lo", bus.lo_q, 32'd0);
        check("t6_div_a", bus.div_a, 32'd0);
        check("t6_mult_a", bus.mult_a, 32'd0);
        repeat (2) step();
        reset = 1'b0;
        repeat (40) step();
        check("t6_nocap_hi", bus.hi_q, 32'd0);
        check("t6_nocap_lo", bus.lo_q, 32'd0);
        issue(OP_DIV, 32'd9, 32'd2, w);
        wait_idle(n);
        check("t6_hi", bus.hi_q, 32'd1);
        check("t6_lo", bus.lo_q, 32'd4);

        step();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
